// File: rtl/gate_stim_pkg.sv
// Shared definitions for the gate stimulus/checker block.
//   state_e          : controller states
//   Res*             : bit positions of each gate result within the 8-bit RES word
//   SettleMin/Max    : legal range of the SETTLE parameter
//   settle_load()    : clamps SETTLE and returns the DRIVE down-counter preload
package gate_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StFin
  } state_e;

  // RES bit positions, MSB first.
  localparam int unsigned ResAnd  = 7;
  localparam int unsigned ResOr   = 6;
  localparam int unsigned ResNand = 5;
  localparam int unsigned ResNor  = 4;
  localparam int unsigned ResXor  = 3;
  localparam int unsigned ResXnor = 2;
  localparam int unsigned ResAInv = 1;
  localparam int unsigned ResBBuf = 0;

  localparam int unsigned SettleMin = 1;
  localparam int unsigned SettleMax = 15;

  localparam logic [7:0] ErrMax  = 8'hFF;
  localparam logic [1:0] LastVec = 2'd3;

  // The DRIVE counter runs from SETTLE-1 down to 0, so DRIVE lasts SETTLE cycles.
  function automatic logic [3:0] settle_load(input int unsigned settle);
    int unsigned s;
    s = settle;
    if (s < SettleMin) s = SettleMin;
    if (s > SettleMax) s = SettleMax;
    return 4'(s - 1);
  endfunction

endpackage

// File: rtl/gate_stim_check_if.sv
// Bus between the gate stimulus/checker and its environment.
//   start    : run request, sampled on the rising clock edge
//   reps     : number of 4-vector sweeps, sampled with start (0 means 1)
//   res      : gate block results {AND, OR, NAND, NOR, XOR, XNOR, ~A, B}
//   a, b     : registered stimulus to the gate block
//   busy     : run in progress (DRIVE/SAMPLE)
//   done     : one-cycle end-of-run pulse
//   pass     : last run finished with zero mismatches
//   err_cnt  : saturating mismatch count
//   fail_vec : {a,b} of the first failing vector (zero unless logging is built)
//   fail_res : res captured at the first failure (zero unless logging is built)
interface gate_stim_check_if;

  logic       start;
  logic [7:0] reps;
  logic [7:0] res;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;
  logic [7:0] fail_res;

  // Environment side: requests runs and returns gate results.
  modport master (
    output start,
    output reps,
    output res,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_vec,
    input  fail_res
  );

  // Checker side.
  modport slave (
    input  start,
    input  reps,
    input  res,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_vec,
    output fail_res
  );

endinterface

// File: rtl/gate_expect.sv
// Combinational reference for the gate block under test.
//   a, b     : stimulus currently driven
//   expected : {a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b), ~a, b}
module gate_expect
  import gate_stim_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);

  always_comb begin
    expected          = '0;
    expected[ResAnd]  = a & b;
    expected[ResOr]   = a | b;
    expected[ResNand] = ~(a & b);
    expected[ResNor]  = ~(a | b);
    expected[ResXor]  = a ^ b;
    expected[ResXnor] = ~(a ^ b);
    expected[ResAInv] = ~a;
    expected[ResBBuf] = b;
  end

endmodule

// File: rtl/gate_stim_check.sv
// Gate stimulus generator and result checker.
// Sweeps {a,b} through 00, 01, 10, 11, holding each vector SETTLE cycles before
// comparing the gate results against gate_expect for one cycle. Repeats for the
// requested number of sweeps, then pulses done and reports pass / err_cnt.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gate_stim_check_if.slave (start, reps, res in; a, b, busy, done,
//           pass, err_cnt, fail_vec, fail_res out)
// Parameter:
//   SETTLE : DRIVE cycles per vector, 1..15 (clamped)
// Build option:
//   GATE_STIM_FAIL_LOG_EN : when defined, capture {a,b} and res of the first
//                           mismatch of each run; otherwise fail_vec/fail_res are 0.
module gate_stim_check
  import gate_stim_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_stim_check_if.slave bus
);

  localparam logic [3:0] SettleLoad = settle_load(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] sweep_q, sweep_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d;
  logic       b_q, b_d;

  logic [7:0] expected;
  logic       mismatch;
  logic       run_start;
  logic       first_fail;

  gate_expect u_expect (
    .a        (a_q),
    .b        (b_q),
    .expected (expected)
  );

  // Any number of differing bits is a single mismatch.
  assign mismatch = (bus.res != expected);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweep_d    = sweep_q;
    settle_d   = settle_q;
    err_d      = err_q;
    pass_d     = pass_q;
    run_start  = 1'b0;
    first_fail = 1'b0;
    a_d        = 1'b0;
    b_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StDrive;
          idx_d     = '0;
          sweep_d   = (bus.reps == '0) ? 8'd1 : bus.reps;
          settle_d  = SettleLoad;
          err_d     = '0;
          pass_d    = 1'b0;
          run_start = 1'b1;
        end
      end

      StDrive: begin
        if (settle_q == '0) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      StSample: begin
        if (mismatch) begin
          first_fail = (err_q == '0);
          if (err_q != ErrMax) begin
            err_d = err_q + 8'd1;
          end
        end
        if (idx_q != LastVec) begin
          idx_d    = idx_q + 2'd1;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end else if (sweep_q > 8'd1) begin
          idx_d    = '0;
          sweep_d  = sweep_q - 8'd1;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end else begin
          state_d = StFin;
          // Uses err_d so a mismatch on the very last vector is counted.
          pass_d  = (err_d == '0);
        end
      end

      StFin: begin
        state_d = StIdle;
        idx_d   = '0;
        sweep_d = '0;
      end

      default: state_d = StIdle;
    endcase

    // Stimulus follows the next state so a/b are registered alongside it.
    if (state_d == StDrive || state_d == StSample) begin
      a_d = idx_d[1];
      b_d = idx_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      sweep_q  <= '0;
      settle_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.busy    = (state_q == StDrive) || (state_q == StSample);
  assign bus.done    = (state_q == StFin);
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

`ifdef GATE_STIM_FAIL_LOG_EN
  logic [1:0] fail_vec_q;
  logic [7:0] fail_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q <= '0;
      fail_res_q <= '0;
    end else if (run_start) begin
      fail_vec_q <= '0;
      fail_res_q <= '0;
    end else if (first_fail) begin
      fail_vec_q <= {a_q, b_q};
      fail_res_q <= bus.res;
    end
  end

  assign bus.fail_vec = fail_vec_q;
  assign bus.fail_res = fail_res_q;
`else
  logic unused_fail_log;
  assign unused_fail_log = run_start ^ first_fail;

  assign bus.fail_vec = '0;
  assign bus.fail_res = '0;
`endif

endmodule
